periph_timer_bus: RTL and testbench

Memory-mapped peripheral block consumed by the MEM stage: decodes the data-memory address/read/write strobes for the 0x4000_00xx I/O window and returns read data in the same cycle. Holds the interval timer (TH/TL/TCON) that drives `irqout` back to the ID stage, plus the LED, switch, seven-segment (`digi`) and free-running systick registers. Addresses outside the window are ignored, and data RAM handles them.

---
 rtl/periph_timer_bus.sv | 82 ++++++++
 tb/tb_periph_timer_bus.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/periph_timer_bus.sv
// periph_timer_bus: timer/LED/switch/digi/systick I/O window; `SWITCH_SYNC_EN adds a 2-flop switch synchronizer
module periph_timer_bus #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irqout
);
  typedef enum logic {IDLE, COUNT} state_t;
  state_t state, state_d;
  logic [31:0] th, tl, tl_d, systick;
  logic [2:0]  tcon, tcon_d;
  logic [7:0]  sw;
  logic        hit, we;
  logic [2:0]  sel;
  logic        unused_addr;
  assign hit = addr[31:5] == BASE_ADDR[31:5];
  assign sel = addr[4:2];
  assign we = wr & hit;
  assign irqout = tcon[2];
  assign unused_addr = ^addr[1:0];
`ifdef SWITCH_SYNC_EN
  logic [7:0] sw_meta;
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) {sw, sw_meta} <= '0;
    else {sw, sw_meta} <= {sw_meta, switch};
`else
  assign sw = switch;
`endif
  // CPU writes are applied last so they override increment, reload and irq set
  always_comb begin
    tl_d = tl;
    tcon_d = tcon;
    if (state == COUNT) begin
      tl_d = &tl ? th : tl + 32'd1;
      tcon_d[2] = tcon[2] | (&tl & tcon[1]);
    end
    if (we && sel == 3'd1) tl_d = wdata;
    if (we && sel == 3'd2) tcon_d = wdata[2:0];
    state_d = tcon_d[0] ? COUNT : IDLE;
  end
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      state <= IDLE;
      th <= '0;
      tl <= '0;
      tcon <= '0;
      led <= '0;
      digi <= '0;
      systick <= '0;
    end else begin
      state <= state_d;
      tl <= tl_d;
      tcon <= tcon_d;
      systick <= systick + 32'd1;
      if (we && sel == 3'd0) th <= wdata;
      if (we && sel == 3'd3) led <= wdata[7:0];
      if (we && sel == 3'd5) digi <= wdata[11:0];
    end
  always_comb begin
    rdata = '0;
    if (rd && hit)
      case (sel)
        3'd0: rdata = th;
        3'd1: rdata = tl;
        3'd2: rdata = {29'd0, tcon};
        3'd3: rdata = {24'd0, led};
        3'd4: rdata = {24'd0, sw};
        3'd5: rdata = {20'd0, digi};
        3'd6: rdata = systick;
        default: rdata = '0;
      endcase
  end
endmodule

// File: tb/tb_periph_timer_bus.sv
// tb_periph_timer_bus: scoreboard bench for the timer/LED/switch/digi I/O block
module tb_periph_timer_bus;
  localparam logic [31:0] A_TH = 32'h4000_0000, A_TL = 32'h4000_0004, A_TCON = 32'h4000_0008,
    A_LED = 32'h4000_000C, A_SW = 32'h4000_0010, A_DIGI = 32'h4000_0014, A_TICK = 32'h4000_0018;
  logic clk, reset_b, rd, wr, irqout;
  logic [31:0] addr, wdata, rdata, tick, e;
  logic [7:0] switch, led;
  logic [11:0] digi;
  logic [31:0] exp_q[$];
  int n_vec, n_err;
  periph_timer_bus dut (.clk(clk), .reset_b(reset_b), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .switch(switch), .led(led), .digi(digi), .irqout(irqout));
  always #50 clk = ~clk;
  always @(posedge clk or negedge reset_b)
    if (!reset_b) tick <= 0;
    else tick <= tick + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic rd_at(input string tag, input logic [31:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    addr = a;
    rd = 1;
    #1;
    check(tag, rdata, exp_q.pop_front());
    rd = 0;
  endtask
  task automatic wr_at(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    wr = 1;
    @(negedge clk);
    wr = 0;
  endtask
  initial begin
    clk = 0; reset_b = 0; rd = 0; wr = 0; addr = 0; wdata = 0; switch = 0;
    #20;
    check("rst_rdata", rdata, 0);
    check("rst_irq", irqout, 0);
    check("rst_led", led, 0);
    check("rst_digi", digi, 0);
    @(negedge clk);
    reset_b = 1;
    @(negedge clk);
    for (int i = 0; i < 8; i++)
      rd_at($sformatf("rst_off%0h", i * 4), A_TH + 32'(i * 4),
            i == 4 ? {24'd0, switch} : (i == 6 ? tick : 32'd0));
    // overflow with interrupt enabled
    wr_at(A_TH, 32'hFFFF_FFF0);
    wr_at(A_TL, 32'hFFFF_FFFC);
    wr_at(A_TCON, 3);
    rd_at("tl0", A_TL, 32'hFFFF_FFFC);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      e = i < 4 ? 32'hFFFF_FFFC + 32'(i) : 32'hFFFF_FFF0 + 32'(i - 4);
      rd_at($sformatf("tl_run%0d", i), A_TL, e);
      check($sformatf("irq_run%0d", i), irqout, 32'(i >= 4));
    end
    @(negedge clk);
    check("irq_hold", irqout, 1);
    rd_at("tcon_set", A_TCON, 7);
    wr_at(A_TCON, 3);
    check("irq_clr", irqout, 0);
    rd_at("tcon_clr", A_TCON, 3);
    // overflow with interrupt disabled
    wr_at(A_TCON, 0);
    wr_at(A_TL, 32'hFFFF_FFFC);
    wr_at(A_TCON, 1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      e = i < 4 ? 32'hFFFF_FFFC + 32'(i) : 32'hFFFF_FFF0 + 32'(i - 4);
      rd_at($sformatf("tl_noirq%0d", i), A_TL, e);
      check($sformatf("irq_off%0d", i), irqout, 0);
    end
    rd_at("tcon_noirq", A_TCON, 1);
    // TL write on the overflow edge wins
    wr_at(A_TCON, 0);
    wr_at(A_TL, 32'hFFFF_FFFD);
    wr_at(A_TCON, 1);
    @(negedge clk);
    @(negedge clk);
    rd_at("tl_pre", A_TL, 32'hFFFF_FFFF);
    wr_at(A_TL, 5);
    rd_at("tl_wr_ovf", A_TL, 5);
    @(negedge clk);
    rd_at("tl_after5", A_TL, 6);
    // TCON write on the overflow edge wins over irq set, reload still happens
    wr_at(A_TCON, 0);
    wr_at(A_TL, 32'hFFFF_FFFD);
    wr_at(A_TCON, 3);
    @(negedge clk);
    @(negedge clk);
    wr_at(A_TCON, 3);
    check("irq_tcon_ovf", irqout, 0);
    rd_at("tcon_ovf", A_TCON, 3);
    rd_at("tl_reload", A_TL, 32'hFFFF_FFF0);
    // disabling on the overflow edge still reloads
    wr_at(A_TCON, 0);
    wr_at(A_TL, 32'hFFFF_FFFE);
    wr_at(A_TCON, 3);
    @(negedge clk);
    wr_at(A_TCON, 0);
    rd_at("tl_dis_ovf", A_TL, 32'hFFFF_FFF0);
    rd_at("tcon_dis_ovf", A_TCON, 0);
    check("irq_dis_ovf", irqout, 0);
    @(negedge clk);
    rd_at("tl_idle_hold", A_TL, 32'hFFFF_FFF0);
    // LED / DIGI truncation, dropped writes
    wr_at(A_LED, 32'h1A5);
    wr_at(A_DIGI, 32'hFABC);
    wr_at(A_SW, 32'hFFFF_FFFF);
    wr_at(32'h4000_0020, 32'h1234_5678);
    check("led", led, 32'hA5);
    check("digi", digi, 32'hABC);
    rd_at("rd_led", A_LED, 32'hA5);
    rd_at("rd_digi", A_DIGI, 32'hABC);
    rd_at("rd_out_win", 32'h4000_0020, 0);
    rd_at("rd_unmapped", 32'h4000_001C, 0);
    rd_at("rd_th_keep", A_TH, 32'hFFFF_FFF0);
    rd_at("rd_sw_keep", A_SW, 0);
    rd_at("rd_wr_off", A_LED, 32'hA5);
    // simultaneous read and write returns the old value
    exp_q.push_back(32'hA5);
    addr = A_LED; wdata = 32'h33; wr = 1; rd = 1;
    #1;
    check("rdwr_old", rdata, exp_q.pop_front());
    rd = 0;
    @(negedge clk);
    wr = 0;
    rd_at("rdwr_new", A_LED, 32'h33);
    check("led_new", led, 32'h33);
    // switch path
    switch = 8'h5A;
`ifdef SWITCH_SYNC_EN
    rd_at("sw_0", A_SW, 0);
    @(negedge clk);
    rd_at("sw_1", A_SW, 0);
`else
    rd_at("sw_0", A_SW, 32'h5A);
    @(negedge clk);
    rd_at("sw_1", A_SW, 32'h5A);
`endif
    @(negedge clk);
    rd_at("sw_2", A_SW, 32'h5A);
    // asynchronous reset mid-count
    wr_at(A_TCON, 0);
    wr_at(A_TH, 0);
    wr_at(A_TL, 32'hFFFF_FFFE);
    wr_at(A_TCON, 3);
    @(negedge clk);
    @(negedge clk);
    check("irq_pre_rst", irqout, 1);
    #5;
    reset_b = 0;
    #1;
    check("irq_async_rst", irqout, 0);
    check("led_async_rst", led, 0);
    rd_at("tl_async_rst", A_TL, 0);
    rd_at("tcon_async_rst", A_TCON, 0);
    rd_at("tick_async_rst", A_TICK, 0);
    @(negedge clk);
    reset_b = 1;
    @(negedge clk);
    @(negedge clk);
    rd_at("tl_no_resume", A_TL, 0);
    rd_at("tcon_no_resume", A_TCON, 0);
    rd_at("tick_resume", A_TICK, tick);
    check("tick_count", tick, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
